dec_bpv_parser: RTL and testbench
=================================

Name: dec_bpv_parser

Overview:
- Sequential, parametrised block-prediction-vector (BPV) parser for the VDC-M decoder BP path.
- Takes one block's suffix window through a valid/ready handshake and extracts 0, 1, 2 or 4 BPVs serially, one per cycle.
- Each extracted BPV gets the FLS offset when required.
- Presents the BPVs, total BPV bit count and the left-aligned remaining suffix to the downstream ECG coefficient decoder.

Parameters:
- BPV_NUM_BITS, 6, full BPV field width B; FLS blocks use B-1 bits; legal range 2..63.
- SUFFIX_W, 128, suffix window width; must be >= 4*B.
- MAX_BPV, 4, number of BPV output slots; fixed at 4 (1x1 partitioning).
- BPV_LIMIT, 64, exclusive upper bound for a legal BPV; used only with the range-check feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  block descriptor valid
- in_ready  out  1  parser can accept
- in_is_fls  in  1  first-line-of-slice block
- in_part_mode  in  2  0=one 2x2 BPV, 1=two 2x1 BPVs, 2=four 1x1 BPVs, 3=non-BP (no BPV)
- in_suffix  in  SUFFIX_W  bitstream window, MSB first
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_bpv  out  MAX_BPV*B  packed BPVs, slot 0 in LSBs
- out_bpv_cnt  out  3  BPVs extracted (0/1/2/4)
- out_bpv_size  out  8  bits consumed by BPVs
- out_suffix_rem  out  SUFFIX_W  suffix shifted left by out_bpv_size, zero filled
- bpv_err  out  1  range violation (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: state=IDLE; in_ready=1; out_valid=0; all out_* registers =0; bpv_err=0.
- k = in_is_fls ? B-1 : B, latched at accept.
- off = in_is_fls ? 2^(B-1) : 0. For B=6 the offset is 32.
- FSM IDLE:
  - in_ready=1.
  - On in_valid: latch suffix into a shift register; latch k, off and target count (mode 0/1/2/3 -> 1/2/4/0).
  - Clear bpv slots, size, idx and err.
  - Go to EXTRACT, or straight to DONE if target=0.
- FSM EXTRACT, each cycle:
  - slot[idx] = top k bits of the shift register, zero-extended to B, plus off.
  - Shift the register left by k.
  - size += k; idx++.
  - When idx reaches target-1 this cycle, go to DONE.
- FSM DONE:
  - out_valid=1; all outputs held stable while out_ready=0.
  - On out_ready: if in_valid is also high, accept the new block the same cycle (in_ready = IDLE | (DONE & out_ready)). Otherwise return to IDLE.
- Latency: accept at cycle T gives out_valid at T+1+target. Mode 3 gives T+1.
- Unused slots read 0. out_suffix_rem equals the final shift-register contents.
- out_bpv_size maximum is 4*B. Arithmetic is unsigned and never wraps for legal B.
- The offset is added after extraction. Since slot value < 2^(B-1) in FLS, no carry out of B bits occurs.
- in_* is sampled only at accept. Changes at other times are ignored.
- rst mid-EXTRACT or mid-DONE discards the block and returns to the reset state next cycle.

Optional Feature:
- Macro: DEC_BPV_RANGE_CHECK_EN.
- When defined:
  - bpv_err is a registered flag, cleared at accept.
  - It is set if any extracted slot value (after offset) is >= BPV_LIMIT.
  - It stays valid with out_valid.
- When undefined: bpv_err is tied 0 and BPV_LIMIT is unused.

Decomposition:
- Package dec_bpv_pkg:
  - partition-mode encodings (PM_2X2, PM_2X1, PM_1X1, PM_NONE);
  - FSM state enum (IDLE, EXTRACT, DONE);
  - function bpv_count(mode);
  - function fls_offset(B).
- One sub-module, dec_bpv_extract: combinational top-k slice plus offset add, parametrised by B and SUFFIX_W. Instantiated once in the parser.

Test Plan (B=6, SUFFIX_W=128; accept cycle T):
1. Mode 0, fls=0, suffix[127:122]=101101 -> bpv0=45, cnt=1, size=6, rem=suffix<<6, out_valid at T+2.
2. Mode 1, fls=1, suffix[127:118]=10101_00011 -> bpv0=53, bpv1=35, cnt=2, size=10, rem=suffix<<10, out_valid at T+3.
3. Mode 2, fls=0, suffix[127:104]=0xFFF000 -> bpv=63,63,0,0, cnt=4, size=24, out_valid at T+5.
4. Mode 3, any suffix -> cnt=0, size=0, out_bpv=0, rem=suffix, out_valid at T+1.
5. Backpressure: hold out_ready=0 for 3 cycles after test 1 -> outputs stable, in_ready=0. Then assert out_ready with in_valid=1 (test 2 data) -> accepted that cycle, test 2 result at +3.
6. rst=1 during EXTRACT of test 3 -> next cycle out_valid=0, in_ready=1, all outputs 0.
   - With DEC_BPV_RANGE_CHECK_EN and BPV_LIMIT=40, rerun test 2 -> bpv_err=1.

Source files
------------

// File: rtl/dec_bpv_pkg.sv
// Shared types and helpers for the VDC-M block-prediction-vector parser.
// Partition-mode encodings, parser FSM states, BPV count and FLS offset helpers.
package dec_bpv_pkg;

    localparam logic [1:0] PM_2X2  = 2'd0;
    localparam logic [1:0] PM_2X1  = 2'd1;
    localparam logic [1:0] PM_1X1  = 2'd2;
    localparam logic [1:0] PM_NONE = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StExtract,
        StDone
    } bpv_state_e;

    function automatic logic [2:0] bpv_count(input logic [1:0] mode);
        case (mode)
            PM_2X2:  return 3'd1;
            PM_2X1:  return 3'd2;
            PM_1X1:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [63:0] fls_offset(input int unsigned b);
        return 64'd1 << (b - 1);
    endfunction

endpackage

// File: rtl/dec_bpv_extract.sv
// Combinational BPV slice: top k bits of the window plus offset, and the window
// advanced past them.
module dec_bpv_extract #(
    parameter int unsigned B        = 6,
    parameter int unsigned SUFFIX_W = 128
) (
    input  logic [SUFFIX_W-1:0] win_i,
    input  logic [7:0]          k_i,
    input  logic [B-1:0]        off_i,
    output logic [B-1:0]        bpv_o,
    output logic [SUFFIX_W-1:0] win_o
);

    logic [B-1:0] head;
    logic [B-1:0] raw;

    assign head = win_i[SUFFIX_W-1 -: B];
    // k is B or B-1, so a right shift of the B-bit head yields the top k bits.
    assign raw   = head >> (8'(B) - k_i);
    assign bpv_o = raw + off_i;
    assign win_o = win_i << k_i;

endmodule

// File: rtl/dec_bpv_parser.sv
// Serial BPV parser: accepts one block suffix window and extracts 0/1/2/4 BPVs.
// Optional range check enabled by defining DEC_BPV_RANGE_CHECK_EN.
module dec_bpv_parser
    import dec_bpv_pkg::*;
#(
    parameter int unsigned BPV_NUM_BITS = 6,
    parameter int unsigned SUFFIX_W     = 128,
    parameter int unsigned MAX_BPV      = 4,
    parameter int unsigned BPV_LIMIT    = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_is_fls,
    input  logic [1:0]                       in_part_mode,
    input  logic [SUFFIX_W-1:0]              in_suffix,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MAX_BPV*BPV_NUM_BITS-1:0]  out_bpv,
    output logic [2:0]                       out_bpv_cnt,
    output logic [7:0]                       out_bpv_size,
    output logic [SUFFIX_W-1:0]              out_suffix_rem,
    output logic                             bpv_err
);

    localparam int unsigned B = BPV_NUM_BITS;
    localparam logic [63:0] FlsOff64 = fls_offset(B);
    localparam logic [B-1:0] FlsOff = FlsOff64[B-1:0];

    if (B < 2 || B > 63 || SUFFIX_W < 4 * B || MAX_BPV != 4 || BPV_LIMIT == 0)
    begin : gen_param_check
        $error("dec_bpv_parser: illegal parameter combination");
    end

    bpv_state_e          state_q, state_d;
    logic [SUFFIX_W-1:0] shreg_q, shreg_d;
    logic [7:0]          k_q, k_d;
    logic [B-1:0]        off_q, off_d;
    logic [2:0]          tgt_q, tgt_d;
    logic [1:0]          idx_q, idx_d;
    logic [7:0]          size_q, size_d;
    logic [B-1:0]        slot_q [MAX_BPV];
    logic [B-1:0]        slot_d [MAX_BPV];
    logic [B-1:0]        ext_bpv;
    logic [SUFFIX_W-1:0] ext_win;
    logic                accept;

    dec_bpv_extract #(
        .B        (B),
        .SUFFIX_W (SUFFIX_W)
    ) u_extract (
        .win_i (shreg_q),
        .k_i   (k_q),
        .off_i (off_q),
        .bpv_o (ext_bpv),
        .win_o (ext_win)
    );

    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef DEC_BPV_RANGE_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        k_d     = k_q;
        off_d   = off_q;
        tgt_d   = tgt_q;
        idx_d   = idx_q;
        size_d  = size_q;
        slot_d  = slot_q;
`ifdef DEC_BPV_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            StExtract: begin
                slot_d[idx_q] = ext_bpv;
                shreg_d       = ext_win;
                size_d        = size_q + k_q;
                idx_d         = idx_q + 2'd1;
`ifdef DEC_BPV_RANGE_CHECK_EN
                if (64'(ext_bpv) >= 64'(BPV_LIMIT)) begin
                    err_d = 1'b1;
                end
`endif
                if ({1'b0, idx_q} == tgt_q - 3'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready && !in_valid) begin
                    state_d = StIdle;
                end
            end
            default: ;
        endcase
        // An accept from DONE overrides the return to IDLE and starts the next block.
        if (accept) begin
            shreg_d = in_suffix;
            k_d     = in_is_fls ? 8'(B - 1) : 8'(B);
            off_d   = in_is_fls ? FlsOff : '0;
            tgt_d   = bpv_count(in_part_mode);
            idx_d   = '0;
            size_d  = '0;
            for (int i = 0; i < MAX_BPV; i++) begin
                slot_d[i] = '0;
            end
`ifdef DEC_BPV_RANGE_CHECK_EN
            err_d   = 1'b0;
`endif
            state_d = (bpv_count(in_part_mode) == 3'd0) ? StDone : StExtract;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            k_q     <= '0;
            off_q   <= '0;
            tgt_q   <= '0;
            idx_q   <= '0;
            size_q  <= '0;
            for (int i = 0; i < MAX_BPV; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            k_q     <= k_d;
            off_q   <= off_d;
            tgt_q   <= tgt_d;
            idx_q   <= idx_d;
            size_q  <= size_d;
            slot_q  <= slot_d;
        end
    end

`ifdef DEC_BPV_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign bpv_err = err_q;
`else
    assign bpv_err = 1'b0;
`endif

    for (genvar i = 0; i < MAX_BPV; i++) begin : gen_pack
        assign out_bpv[i*B +: B] = slot_q[i];
    end

    assign out_valid      = (state_q == StDone);
    assign out_bpv_cnt    = tgt_q;
    assign out_bpv_size   = size_q;
    assign out_suffix_rem = shreg_q;

endmodule

// File: tb/tb_dec_bpv_parser.sv
// Self-checking bench for dec_bpv_parser: directed vectors plus a reference model
// checked on every valid output cycle.
module tb_dec_bpv_parser;

    localparam int B  = 6;
    localparam int SW = 128;
`ifdef DEC_BPV_RANGE_CHECK_EN
    localparam int LIM = 40;
`else
    localparam int LIM = 64;
`endif

    localparam logic [127:0] S1 = 128'hB4C3D2E1F00F123456789ABCDEF01357;
    localparam logic [127:0] S2 = 128'hA8F1E2D3C4B5A69788796A5B4C3D2E1F;
    localparam logic [127:0] S3 = 128'hFFF00055AA123456789ABCDEF0112233;
    localparam logic [127:0] S4 = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_is_fls;
    logic [1:0]    in_part_mode;
    logic [SW-1:0] in_suffix;
    logic          out_valid;
    logic          out_ready;
    logic [4*B-1:0] out_bpv;
    logic [2:0]    out_bpv_cnt;
    logic [7:0]    out_bpv_size;
    logic [SW-1:0] out_suffix_rem;
    logic          bpv_err;

    always #5 clk = ~clk;

    dec_bpv_parser #(
        .BPV_NUM_BITS (B),
        .SUFFIX_W     (SW),
        .MAX_BPV      (4),
        .BPV_LIMIT    (LIM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_fls      (in_is_fls),
        .in_part_mode   (in_part_mode),
        .in_suffix      (in_suffix),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_bpv        (out_bpv),
        .out_bpv_cnt    (out_bpv_cnt),
        .out_bpv_size   (out_bpv_size),
        .out_suffix_rem (out_suffix_rem),
        .bpv_err        (bpv_err)
    );

    typedef struct {
        logic [4*B-1:0] bpv;
        logic [2:0]     cnt;
        logic [7:0]     size;
        logic [SW-1:0]  rem;
        logic           err;
        int             due;
        bit             seen;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    bit   rnd_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: BPV j occupies suffix bits starting at MSB-first position j*k.
    function automatic exp_t model(input bit fls, input logic [1:0] mode, input logic [127:0] s);
        exp_t          e;
        int            n;
        int            k;
        longint        off;
        longint        v;
        logic [127:0]  mask;
        n = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 0;
        k = fls ? B - 1 : B;
        off = fls ? (64'd1 << (B - 1)) : 0;
        mask = (128'd1 << k) - 128'd1;
        e.bpv = '0;
        e.err = 1'b0;
        for (int j = 0; j < n; j++) begin
            v = longint'((s >> (128 - (j + 1) * k)) & mask) + off;
            e.bpv[j*B +: B] = B'(v);
`ifdef DEC_BPV_RANGE_CHECK_EN
            if (v >= LIM) e.err = 1'b1;
`endif
        end
        e.cnt  = 3'(n);
        e.size = 8'(n * k);
        e.rem  = s << (n * k);
        e.due  = 0;
        e.seen = 1'b0;
        return e;
    endfunction

    always @(posedge clk) begin : mon
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) chk("in_ready_in_done", in_ready, out_ready);
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                e = model(in_is_fls, in_part_mode, in_suffix);
                e.due = cyc + 1 + int'(e.cnt);
                exp_q.push_back(e);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got out_valid=1 want no pending block");
            end else begin
                if (!exp_q[0].seen) begin
                    chk("latency", cyc, exp_q[0].due);
                    exp_q[0].seen = 1'b1;
                end
                chk("bpv", out_bpv, exp_q[0].bpv);
                chk("cnt", out_bpv_cnt, exp_q[0].cnt);
                chk("size", out_bpv_size, exp_q[0].size);
                chk("rem", out_suffix_rem, exp_q[0].rem);
                chk("err", bpv_err, exp_q[0].err);
            end
        end
    end

    always @(negedge clk) begin
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input bit fls, input logic [1:0] mode, input logic [127:0] s);
        bit done;
        done = 1'b0;
        in_is_fls    = fls;
        in_part_mode = mode;
        in_suffix    = s;
        in_valid     = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (in_ready) done = 1'b1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_suffix = ~s;
        in_is_fls = ~fls;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1 within 200 cycles");
        end
    endtask

    task automatic wait_valid();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (out_valid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got out_valid=0 want 1 within 50 cycles");
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_bpv"}, out_bpv, '0);
        chk({tag, "_cnt"}, out_bpv_cnt, '0);
        chk({tag, "_size"}, out_bpv_size, '0);
        chk({tag, "_rem"}, out_suffix_rem, '0);
        chk({tag, "_err"}, bpv_err, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_is_fls    = 1'b0;
        in_part_mode = 2'd0;
        in_suffix    = '0;
        out_ready    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;
        @(negedge clk);

        // Mode 0 held under backpressure, then accept from DONE in the release cycle.
        out_ready = 1'b0;
        send(1'b0, 2'd0, S1);
        wait_valid();
        chk("t1_bpv0", out_bpv, 24'd45);
        chk("t1_cnt", out_bpv_cnt, 3'd1);
        chk("t1_size", out_bpv_size, 8'd6);
        chk("t1_rem", out_suffix_rem, S1 << 6);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_bpv", out_bpv, 24'd45);
        end
        out_ready = 1'b1;
        send(1'b1, 2'd1, S2);
        wait_valid();
        chk("t2_bpv", out_bpv, {12'd0, 6'd35, 6'd53});
        chk("t2_size", out_bpv_size, 8'd10);
        chk("t2_rem", out_suffix_rem, S2 << 10);
`ifdef DEC_BPV_RANGE_CHECK_EN
        chk("t2_err", bpv_err, 1'b1);
`endif

        send(1'b0, 2'd2, S3);
        wait_valid();
        chk("t3_bpv", out_bpv, {6'd0, 6'd0, 6'd63, 6'd63});
        chk("t3_cnt", out_bpv_cnt, 3'd4);
        chk("t3_size", out_bpv_size, 8'd24);

        send(1'b1, 2'd3, S4);
        wait_valid();
        chk("t4_cnt", out_bpv_cnt, 3'd0);
        chk("t4_bpv", out_bpv, 24'd0);
        chk("t4_rem", out_suffix_rem, S4);

        // Random blocks with random downstream stalls, checked by the model.
        rnd_en = 1'b1;
        repeat (24) begin
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom, $urandom});
        end
        @(negedge clk);
        rnd_en    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain_pending", 128'(exp_q.size()), 128'd0);

        // Reset while extracting discards the block.
        @(negedge clk);
        send(1'b0, 2'd2, S3);
        rst = 1'b1;
        @(negedge clk);
        #1;
        reset_checks("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        send(1'b1, 2'd1, S2);
        wait_valid();
        chk("post_rst_bpv", out_bpv, {12'd0, 6'd35, 6'd53});

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
